// File: rtl/buzzer_driver_if.sv
// Request/status bundle between the control FSM and the buzzer driver.
// The master issues burst requests; the slave drives the pin and reports progress.
interface buzzer_driver_if;
    logic       start;
    logic [2:0] count;
    logic [1:0] tone_sel;
    logic       stop;
    logic       buzzer;
    logic       busy;
    logic       done;

    modport master (output start, count, tone_sel, stop, input buzzer, busy, done);
    modport slave  (input start, count, tone_sel, stop, output buzzer, busy, done);
endinterface

// File: rtl/buzzer_driver.sv
// Piezo buzzer burst generator: 1-7 square-wave beeps of selectable pitch,
// separated by silent gaps, with busy/done status and abort.
module buzzer_driver #(
    parameter int TONE_HALF_BASE = 12500,
    parameter int BEEP_CYCLES    = 5000000,
    parameter int GAP_CYCLES     = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    buzzer_driver_if.slave  bus
);
    localparam int TW   = $clog2(TONE_HALF_BASE << 3);
    localparam int DMAX = (BEEP_CYCLES > GAP_CYCLES) ? BEEP_CYCLES : GAP_CYCLES;
    localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;

    localparam logic [DW-1:0] BEEP_LAST = DW'(BEEP_CYCLES - 1);
    localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BEEP = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] tone_cnt;
    logic [DW-1:0] dur_cnt;
    logic [2:0]    rem_cnt;
    logic [1:0]    tone_q;
    logic          buzzer_q, busy_q, done_q;
    logic [TW-1:0] half_last;

    // Widened before the subtract: the top pitch's full half-period can overflow TW bits.
    always_comb half_last = TW'((TONE_HALF_BASE << tone_q) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tone_cnt <= '0;
            dur_cnt  <= '0;
            rem_cnt  <= '0;
            tone_q   <= '0;
            buzzer_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && bus.count != 3'd0) begin
                        rem_cnt  <= bus.count;
                        tone_q   <= bus.tone_sel;
                        state    <= S_BEEP;
                        busy_q   <= 1'b1;
                        buzzer_q <= 1'b1;
                        tone_cnt <= '0;
                        dur_cnt  <= '0;
                    end
                end
                S_BEEP: begin
                    if (bus.stop) begin
                        state    <= S_IDLE;
                        buzzer_q <= 1'b0;
                        busy_q   <= 1'b0;
                        tone_cnt <= '0;
                        dur_cnt  <= '0;
                        rem_cnt  <= '0;
                    end else if (dur_cnt == BEEP_LAST) begin
                        buzzer_q <= 1'b0;
                        tone_cnt <= '0;
                        dur_cnt  <= '0;
                        if (rem_cnt > 3'd1) begin
                            rem_cnt <= rem_cnt - 3'd1;
                            state   <= S_GAP;
                        end else begin
                            rem_cnt <= '0;
                            state   <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + 1'b1;
                        if (tone_cnt == half_last) begin
                            tone_cnt <= '0;
                            buzzer_q <= ~buzzer_q;
                        end else begin
                            tone_cnt <= tone_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (bus.stop) begin
                        state    <= S_IDLE;
                        buzzer_q <= 1'b0;
                        busy_q   <= 1'b0;
                        tone_cnt <= '0;
                        dur_cnt  <= '0;
                        rem_cnt  <= '0;
                    end else if (dur_cnt == GAP_LAST) begin
                        // Every beep restarts its tone phase high.
                        state    <= S_BEEP;
                        buzzer_q <= 1'b1;
                        tone_cnt <= '0;
                        dur_cnt  <= '0;
                    end else begin
                        dur_cnt <= dur_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.buzzer = buzzer_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_buzzer_driver.sv
// Directed bench for buzzer_driver: per-cycle expected pin/status trace held in a
// scoreboard queue, built from the burst timing rules and popped every clock.
module tb_buzzer_driver;
    localparam int BASE = 2;
    localparam int BEEP = 16;
    localparam int GAP  = 8;

    typedef struct packed {
        logic buzzer;
        logic busy;
        logic done;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    buzzer_driver_if bus ();

    buzzer_driver #(
        .TONE_HALF_BASE(BASE),
        .BEEP_CYCLES   (BEEP),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    resp_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;

    // Expected trace of a whole burst, starting with the first beep cycle.
    task automatic push_burst(input int n, input int h);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < BEEP; c++)
                sb.push_back('{buzzer: ((c / h) % 2 == 0), busy: 1'b1, done: 1'b0});
            if (b < n - 1)
                for (int g = 0; g < GAP; g++)
                    sb.push_back('{buzzer: 1'b0, busy: 1'b1, done: 1'b0});
        end
        sb.push_back('{buzzer: 1'b0, busy: 1'b0, done: 1'b1});
    endtask

    // One clock; outputs sampled 1 time unit after the edge. Empty queue means idle.
    task automatic tick(input string tag);
        resp_t exp_r;
        resp_t obs_r;
        @(posedge clk);
        #1;
        exp_r = '0;
        if (sb.size() != 0) exp_r = sb.pop_front();
        obs_r = {bus.buzzer, bus.busy, bus.done};
        n_cmp++;
        assert (obs_r === exp_r) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed(buz,busy,done)=%b expected=%b", tag, cyc, obs_r, exp_r);
        end
        cyc++;
    endtask

    task automatic drain(input string tag);
        while (sb.size() != 0) tick(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.count = 3'd0; bus.tone_sel = 2'd0; bus.stop = 1'b0;
        rst = 1'b1;
        repeat (3) tick("reset");
        rst = 1'b0;
        repeat (2) tick("idle");

        // Single beep, highest pitch
        bus.start = 1'b1; bus.count = 3'd1; bus.tone_sel = 2'd0;
        push_burst(1, BASE);
        tick("single");
        bus.start = 1'b0;
        drain("single");
        repeat (2) tick("single_post");

        // count=0 is ignored
        bus.start = 1'b1; bus.count = 3'd0;
        tick("count0");
        bus.start = 1'b0;
        repeat (3) tick("count0_post");

        // Two beeps at H=4, with starts during beep, gap and DONE ignored
        bus.start = 1'b1; bus.count = 3'd2; bus.tone_sel = 2'd1;
        push_burst(2, BASE << 1);
        tick("multi");
        bus.start = 1'b0; bus.count = 3'd3;
        repeat (5) tick("multi");
        bus.start = 1'b1;
        tick("multi_ign_beep");
        bus.start = 1'b0;
        repeat (12) tick("multi");
        bus.start = 1'b1;
        tick("multi_ign_gap");
        bus.start = 1'b0;
        drain("multi");
        bus.start = 1'b1;
        tick("multi_ign_done");
        bus.start = 1'b0;
        repeat (2) tick("multi_post");

        // Abort on the 5th gap cycle, then an immediate fresh request
        bus.start = 1'b1; bus.count = 3'd3; bus.tone_sel = 2'd0;
        push_burst(3, BASE);
        tick("abort");
        bus.start = 1'b0;
        repeat (20) tick("abort");
        bus.stop = 1'b1;
        sb.delete();
        tick("abort_stop");
        bus.stop = 1'b0;
        bus.start = 1'b1; bus.count = 3'd1;
        push_burst(1, BASE);
        tick("abort_restart");
        bus.start = 1'b0;
        drain("abort_restart");
        tick("abort_post");

        // Reset on the 10th cycle of a long low-pitch burst
        bus.start = 1'b1; bus.count = 3'd7; bus.tone_sel = 2'd3;
        push_burst(7, BASE << 3);
        tick("rst_mid");
        bus.start = 1'b0;
        repeat (9) tick("rst_mid");
        rst = 1'b1;
        sb.delete();
        tick("rst_hit");
        rst = 1'b0;
        tick("rst_post");
        bus.start = 1'b1; bus.count = 3'd1; bus.tone_sel = 2'd0;
        push_burst(1, BASE);
        tick("rst_restart");
        bus.start = 1'b0;
        drain("rst_restart");
        tick("rst_restart_post");

        // start and stop together in IDLE: start wins
        bus.start = 1'b1; bus.stop = 1'b1; bus.count = 3'd1;
        push_burst(1, BASE);
        tick("start_stop");
        bus.start = 1'b0; bus.stop = 1'b0;
        drain("start_stop");
        repeat (2) tick("start_stop_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/buzzer_driver.md
# buzzer_driver

Output-side counterpart to the light-sensor input path: where the sensor block turns a pin level into an internal event, this block turns an internal request into a pin waveform. On a one-cycle `start` request it drives a piezo buzzer pin with a burst of 1–7 square-wave beeps. Each beep has a selectable pitch, and beeps are separated by silent gaps. It sits between the game/pet control FSM and the board buzzer pin, reports `busy` while sounding, and pulses `done` on completion.

## Interface
- `TONE_HALF_BASE`, default 12500: half-period of the highest tone, in clk cycles (2 kHz at 50 MHz). Must be ≥1, and `TONE_HALF_BASE<<3` must fit the tone counter.
- `BEEP_CYCLES`, default 5000000: length of one beep in clk cycles (100 ms). Must be ≥1.
- `GAP_CYCLES`, default 5000000: silence between beeps in clk cycles. Must be ≥1.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `count`  in  3  number of beeps (0–7); latched at accept.
- `tone_sel`  in  2  pitch; half-period = `TONE_HALF_BASE << tone_sel`; latched at accept.
- `stop`  in  1  abort; effective only while busy.
- `buzzer`  out  1  square-wave pin drive, registered.
- `busy`  out  1  high from accept through the last beep cycle, registered.
- `done`  out  1  one-cycle completion pulse, registered.

## Operation
- States: IDLE, BEEP, GAP, DONE.
- Internal counters:
  - tone counter: width `$clog2(TONE_HALF_BASE<<3)`;
  - duration counter: width `$clog2(max(BEEP_CYCLES,GAP_CYCLES))`;
  - remaining-beep counter: 3 bits.
- Reset (any state): next edge gives state=IDLE, `buzzer`=0, `busy`=0, `done`=0, all counters 0.
- IDLE, `start`=1 and `count`≠0 (accept):
  - latch `count` and `tone_sel`;
  - next cycle: state=BEEP, `busy`=1, `buzzer`=1, tone and duration counters 0.
- IDLE, `start`=1 and `count`=0: ignored; no `busy`, no `done`.
- BEEP:
  - lasts exactly `BEEP_CYCLES` cycles.
  - Let H be the latched half-period. The tone counter counts 0..H-1; at H-1 it wraps to 0 and `buzzer` toggles.
  - After the last BEEP cycle, `buzzer` is forced to 0.
  - If more than one beep remains: decrement the remaining count and go to GAP.
  - Otherwise: go to DONE.
- GAP:
  - lasts exactly `GAP_CYCLES` cycles with `buzzer`=0;
  - then BEEP, with `buzzer`=1 on its first cycle (phase restarts on every beep).
- DONE: one cycle with `done`=1, `busy`=0, `buzzer`=0; then IDLE.
- `start` while not IDLE, including the DONE cycle: ignored; the in-progress burst is unaffected.
- `stop`=1 in BEEP or GAP:
  - next cycle: state=IDLE, `buzzer`=0, `busy`=0;
  - no `done` pulse.
- `stop` in IDLE or DONE: no effect. `start` and `stop` together in IDLE: start is accepted.
- `rst` mid-burst: the burst is abandoned; no `done` pulse.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Accept latency: `start` sampled high at edge k gives `busy`=`buzzer`=1 after edge k+1.
- With N = latched count, `busy` stays high for exactly N·`BEEP_CYCLES` + (N-1)·`GAP_CYCLES` cycles.
- `done` is high for the single cycle immediately after the final BEEP cycle; `busy` falls in that same cycle.
- Earliest next accept: `start` sampled in the cycle after `done`.
- Toggle count: within one beep, `buzzer` toggles floor((`BEEP_CYCLES`-1)/H) times. A partial half-period at the end of a beep is truncated.
- `stop` latency: 1 cycle to `buzzer`=0 and `busy`=0.

## Test plan
All scenarios use `TONE_HALF_BASE`=2, `BEEP_CYCLES`=16, `GAP_CYCLES`=8.
- Basic single beep: `count`=1, `tone_sel`=0, `start` pulse.
  - `busy` high 16 cycles; `buzzer` pattern 1,1,0,0 repeated 4×.
  - `done` pulses once, on the cycle after the 16th; `buzzer`=0 afterwards.
- Multi-beep, lower pitch: `count`=2, `tone_sel`=1 (H=4).
  - Beep 16 cycles (1111 0000 1111 0000), gap 8 cycles at 0, beep 16 cycles.
  - `busy` high exactly 40 cycles; one `done`.
- Ignored requests:
  - `count`=0 with `start`: `busy` and `done` stay 0.
  - `start` with `count`=3 during a running burst and again during the DONE cycle: no restart; total `busy` stays 2·16+8=40 for the original `count`=2 burst.
- Abort: `count`=3, assert `stop` on the 5th GAP cycle.
  - Next cycle: `busy`=0, `buzzer`=0, state IDLE, no `done`.
  - A fresh `start` 1 cycle later is accepted.
- Reset mid-beep: `count`=7, `tone_sel`=3 (H=16), assert `rst` on BEEP cycle 10.
  - Next edge: `buzzer`=`busy`=`done`=0.
  - After `rst` releases, a new `count`=1 request runs normally (16-cycle `busy`).
- Simultaneous `start`+`stop` in IDLE with `count`=1: accepted; `busy` high 16 cycles, then `done`.
